flit_out_arbiter: RTL and testbench

FLIT_OUT_ARBITER -- requirements
Module: flit_out_arbiter

---
 rtl/flit_out_arbiter_if.sv | 31 +++
 rtl/flit_out_arbiter.sv | 146 ++++++++++++++
 tb/tb_flit_out_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flit_out_arbiter_if.sv
// Flit link between the input ports and the output arbiter: packed input flits
// and downstream ready in; pop strobes, output flit, grant and packet count out.
interface flit_out_arbiter_if #(
  parameter int W_DIR  = 5,
  parameter int W_FLIT = 8
);
  logic [W_DIR*W_FLIT-1:0] IN;
  logic                    RDY;
  logic [W_DIR-1:0]        ACK;
  logic [W_FLIT-1:0]       OUT;
  logic [W_DIR-1:0]        GRANT;
  logic [7:0]              PKT_CNT;

  modport master (
    output IN,
    output RDY,
    input  ACK,
    input  OUT,
    input  GRANT,
    input  PKT_CNT
  );

  modport slave (
    input  IN,
    input  RDY,
    output ACK,
    output OUT,
    output GRANT,
    output PKT_CNT
  );
endinterface

// File: rtl/flit_out_arbiter.sv
// Round-robin output-link arbiter: a flit ACKed in cycle N is on OUT in N+1; OUT holds while RDY=0.
// FLIT_ARB_PKT_LOCK_EN defined: wormhole lock per packet; undefined: every flit arbitrated alone.
module flit_out_arbiter #(
  parameter int W_DIR  = 5,
  parameter int W_FLIT = 8
) (
  input logic              CLK,
  input logic              RST,
  flit_out_arbiter_if.slave bus
);

  localparam int W_PTR = (W_DIR > 1) ? $clog2(W_DIR) : 1;
  typedef logic [W_PTR-1:0] ptr_t;

  logic [W_FLIT-1:0] out_q, out_d;
  logic [W_DIR-1:0]  grant_q, grant_d;
  ptr_t              ptr_q, ptr_d;
  logic [7:0]        cnt_q, cnt_d;

  logic [W_DIR-1:0]  vld;
  logic              free;
  logic              rr_hit;
  ptr_t              rr_idx;
  logic              load;
  ptr_t              sel;
  logic [W_FLIT-1:0] sel_flit;
  logic              sel_tail;
  logic [W_DIR-1:0]  sel_onehot;
  ptr_t              ptr_inc;

`ifdef FLIT_ARB_PKT_LOCK_EN
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state_q, state_d;
  ptr_t   own_q, own_d;
`endif

  always_comb begin
    for (int i = 0; i < W_DIR; i++) begin
      vld[i] = bus.IN[i*W_FLIT + W_FLIT - 1];
    end
  end

  assign free = !out_q[W_FLIT-1] || bus.RDY;

  // Descending scan so the lowest offset from the pointer wins.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int k = W_DIR - 1; k >= 0; k--) begin
      if (vld[ptr_t'((int'(ptr_q) + k) % W_DIR)]) begin
        rr_hit = 1'b1;
        rr_idx = ptr_t'((int'(ptr_q) + k) % W_DIR);
      end
    end
  end

  always_comb begin
    sel  = rr_idx;
    load = free && rr_hit;
`ifdef FLIT_ARB_PKT_LOCK_EN
    if (state_q == LOCK) begin
      sel  = own_q;
      load = free && vld[own_q];
    end
`endif
    if (RST) begin
      load = 1'b0;
    end
  end

  assign sel_flit = bus.IN[int'(sel)*W_FLIT +: W_FLIT];
  assign sel_tail = sel_flit[W_FLIT-2];
  assign ptr_inc  = (sel == ptr_t'(W_DIR - 1)) ? '0 : ptr_t'(sel + 1'b1);

  always_comb begin
    sel_onehot      = '0;
    sel_onehot[sel] = 1'b1;
  end

  always_comb begin
    out_d   = out_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
`ifdef FLIT_ARB_PKT_LOCK_EN
    state_d = state_q;
    own_d   = own_q;
`endif
    if (free) begin
      if (load) begin
        out_d = sel_flit;
        if (sel_tail) begin
          cnt_d = cnt_q + 8'd1;
        end
`ifdef FLIT_ARB_PKT_LOCK_EN
        if (sel_tail) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = ptr_inc;
        end else begin
          state_d = LOCK;
          grant_d = sel_onehot;
          own_d   = sel;
        end
`else
        grant_d = sel_onehot;
        ptr_d   = ptr_inc;
`endif
      end else begin
        // Nothing to send: drain the register; a held lock survives the bubble.
        out_d = '0;
`ifndef FLIT_ARB_PKT_LOCK_EN
        grant_d = '0;
`endif
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_q   <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
`ifdef FLIT_ARB_PKT_LOCK_EN
      state_q <= IDLE;
      own_q   <= '0;
`endif
    end else begin
      out_q   <= out_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
`ifdef FLIT_ARB_PKT_LOCK_EN
      state_q <= state_d;
      own_q   <= own_d;
`endif
    end
  end

  assign bus.ACK     = load ? sel_onehot : '0;
  assign bus.OUT     = out_q;
  assign bus.GRANT   = grant_q;
  assign bus.PKT_CNT = cnt_q;

endmodule

// File: tb/tb_flit_out_arbiter.sv
// Bench for flit_out_arbiter: directed scenarios plus randomized traffic against a queue/int model.
module tb_flit_out_arbiter;

  localparam int W_DIR  = 5;
  localparam int W_FLIT = 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic rdy = 1'b0;
  logic [W_FLIT-1:0] in_flit [W_DIR];
  logic [W_FLIT-1:0] src_q [W_DIR][$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [W_FLIT-1:0] m_out;
  logic [W_DIR-1:0]  m_grant;
  int                m_ptr;
  int                m_own;
  logic [7:0]        m_cnt;

  always #5 CLK = ~CLK;

  flit_out_arbiter_if #(.W_DIR(W_DIR), .W_FLIT(W_FLIT)) bus ();

  flit_out_arbiter #(.W_DIR(W_DIR), .W_FLIT(W_FLIT)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always_comb begin
    bus.IN = '0;
    for (int i = 0; i < W_DIR; i++) bus.IN[i*W_FLIT +: W_FLIT] = in_flit[i];
  end
  assign bus.RDY = rdy;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < W_DIR; i++) begin
      in_flit[i] = '0;
      src_q[i].delete();
    end
  endtask

  task automatic present_heads();
    for (int i = 0; i < W_DIR; i++) in_flit[i] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
  endtask

  task automatic pop_acked(input logic [W_DIR-1:0] ack);
    for (int i = 0; i < W_DIR; i++) if (ack[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
  endtask

  task automatic do_reset();
    RST = 1'b1;
    rdy = 1'b0;
    clear_inputs();
    tick();
    tick();
    RST = 1'b0;
    m_out = '0; m_grant = '0; m_ptr = 0; m_own = -1; m_cnt = '0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    rdy = 1'b1;
    for (int i = 0; i < W_DIR; i++) in_flit[i] = 8'(8'hC0 + i);
    for (int c = 0; c < 2; c++) begin
      #2;
      n_cmp++;
      if (bus.ACK !== 5'b00000) begin n_bad++; $display("FAIL reset_ack: got %b want 00000", bus.ACK); end
      tick();
    end
    n_cmp++;
    if (bus.OUT !== 8'h00) begin n_bad++; $display("FAIL reset_out: got %h want 00", bus.OUT); end
    n_cmp++;
    if (bus.GRANT !== 5'b00000) begin n_bad++; $display("FAIL reset_grant: got %b want 00000", bus.GRANT); end
    n_cmp++;
    if (bus.PKT_CNT !== 8'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", bus.PKT_CNT); end
    RST = 1'b0;
    clear_inputs();
  endtask

  task automatic test_round_robin();
    int ports [3];
    logic [7:0] flits [3];
    logic [W_DIR-1:0] ack;
    ports = '{0, 2, 4};
    flits = '{8'hC1, 8'hC2, 8'hC3};
    do_reset();
    rdy = 1'b1;
    for (int c = 0; c < 3; c++) src_q[ports[c]].push_back(flits[c]);
    for (int c = 0; c < 3; c++) begin
      present_heads();
      #2;
      ack = bus.ACK;
      n_cmp++;
      if (ack !== 5'(1 << ports[c])) begin n_bad++; $display("FAIL rr_ack%0d: got %b want port %0d", c, ack, ports[c]); end
      tick();
      pop_acked(ack);
      n_cmp++;
      if (bus.OUT !== flits[c]) begin n_bad++; $display("FAIL rr_out%0d: got %h want %h", c, bus.OUT, flits[c]); end
`ifdef FLIT_ARB_PKT_LOCK_EN
      n_cmp++;
      if (bus.GRANT !== 5'b00000) begin n_bad++; $display("FAIL rr_grant%0d: got %b want 00000", c, bus.GRANT); end
`else
      n_cmp++;
      if (bus.GRANT !== 5'(1 << ports[c])) begin n_bad++; $display("FAIL rr_grant%0d: got %b want port %0d", c, bus.GRANT, ports[c]); end
`endif
    end
    n_cmp++;
    if (bus.PKT_CNT !== 8'd3) begin n_bad++; $display("FAIL rr_cnt: got %0d want 3", bus.PKT_CNT); end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    logic [W_DIR-1:0] want_ack;
    logic [7:0] want_out;
    do_reset();
    rdy = 1'b1;
    in_flit[0] = 8'h85;
    #2;
    n_cmp++;
    if (bus.ACK !== 5'b00001) begin n_bad++; $display("FAIL bp_first_ack: got %b want 00001", bus.ACK); end
    tick();
    in_flit[0] = 8'hC6;
    in_flit[1] = 8'hC7;
    rdy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (bus.OUT !== 8'h85) begin n_bad++; $display("FAIL bp_hold_out%0d: got %h want 85", c, bus.OUT); end
      n_cmp++;
      if (bus.GRANT !== 5'b00001) begin n_bad++; $display("FAIL bp_hold_grant%0d: got %b want 00001", c, bus.GRANT); end
      #2;
      n_cmp++;
      if (bus.ACK !== 5'b00000) begin n_bad++; $display("FAIL bp_hold_ack%0d: got %b want 00000", c, bus.ACK); end
      tick();
    end
    rdy = 1'b1;
`ifdef FLIT_ARB_PKT_LOCK_EN
    want_ack = 5'b00001; want_out = 8'hC6;
`else
    want_ack = 5'b00010; want_out = 8'hC7;
`endif
    #2;
    n_cmp++;
    if (bus.ACK !== want_ack) begin n_bad++; $display("FAIL bp_resume_ack: got %b want %b", bus.ACK, want_ack); end
    tick();
    n_cmp++;
    if (bus.OUT !== want_out) begin n_bad++; $display("FAIL bp_resume_out: got %h want %h", bus.OUT, want_out); end
    clear_inputs();
  endtask

  task automatic test_interleave();
    int ports [4];
    logic [7:0] outs [4];
    logic [W_DIR-1:0] grants [4];
    logic [W_DIR-1:0] ack;
`ifdef FLIT_ARB_PKT_LOCK_EN
    ports = '{0, 0, 1, 1};
    outs = '{8'h81, 8'hC2, 8'h91, 8'hD2};
    grants = '{5'b00001, 5'b00000, 5'b00010, 5'b00000};
`else
    ports = '{0, 1, 0, 1};
    outs = '{8'h81, 8'h91, 8'hC2, 8'hD2};
    grants = '{5'b00001, 5'b00010, 5'b00001, 5'b00010};
`endif
    do_reset();
    rdy = 1'b1;
    src_q[0].push_back(8'h81); src_q[0].push_back(8'hC2);
    src_q[1].push_back(8'h91); src_q[1].push_back(8'hD2);
    for (int c = 0; c < 4; c++) begin
      present_heads();
      #2;
      ack = bus.ACK;
      n_cmp++;
      if (ack !== 5'(1 << ports[c])) begin n_bad++; $display("FAIL il_ack%0d: got %b want port %0d", c, ack, ports[c]); end
      tick();
      pop_acked(ack);
      n_cmp++;
      if (bus.OUT !== outs[c]) begin n_bad++; $display("FAIL il_out%0d: got %h want %h", c, bus.OUT, outs[c]); end
      n_cmp++;
      if (bus.GRANT !== grants[c]) begin n_bad++; $display("FAIL il_grant%0d: got %b want %b", c, bus.GRANT, grants[c]); end
    end
    clear_inputs();
  endtask

`ifdef FLIT_ARB_PKT_LOCK_EN
  task automatic test_lock();
    int ports [4];
    logic [7:0] outs [4];
    logic [W_DIR-1:0] grants [4];
    logic [W_DIR-1:0] ack;
    ports = '{1, 1, 1, 3};
    outs = '{8'h81, 8'h82, 8'hC3, 8'hC4};
    grants = '{5'b00010, 5'b00010, 5'b00000, 5'b00000};
    do_reset();
    rdy = 1'b1;
    src_q[1].push_back(8'h81); src_q[1].push_back(8'h82); src_q[1].push_back(8'hC3);
    src_q[3].push_back(8'hC4);
    for (int c = 0; c < 4; c++) begin
      present_heads();
      #2;
      ack = bus.ACK;
      n_cmp++;
      if (ack !== 5'(1 << ports[c])) begin n_bad++; $display("FAIL lock_ack%0d: got %b want port %0d", c, ack, ports[c]); end
      tick();
      pop_acked(ack);
      n_cmp++;
      if (bus.OUT !== outs[c]) begin n_bad++; $display("FAIL lock_out%0d: got %h want %h", c, bus.OUT, outs[c]); end
      n_cmp++;
      if (bus.GRANT !== grants[c]) begin n_bad++; $display("FAIL lock_grant%0d: got %b want %b", c, bus.GRANT, grants[c]); end
    end
    clear_inputs();
  endtask
`endif

  task automatic test_bubble_reset();
    logic [W_DIR-1:0] acks [2];
    logic [W_DIR-1:0] grants [2];
    logic vbits [2];
    logic [W_DIR-1:0] ack;
`ifdef FLIT_ARB_PKT_LOCK_EN
    acks = '{5'b00000, 5'b00000};
    grants = '{5'b00100, 5'b00100};
    vbits = '{1'b0, 1'b0};
`else
    acks = '{5'b10000, 5'b00001};
    grants = '{5'b10000, 5'b00001};
    vbits = '{1'b1, 1'b1};
`endif
    do_reset();
    rdy = 1'b1;
    in_flit[2] = 8'hA1;
    #2;
    n_cmp++;
    if (bus.ACK !== 5'b00100) begin n_bad++; $display("FAIL bub_first_ack: got %b want 00100", bus.ACK); end
    tick();
    n_cmp++;
    if (bus.OUT !== 8'hA1) begin n_bad++; $display("FAIL bub_first_out: got %h want a1", bus.OUT); end
    in_flit[2] = 8'h00;
    in_flit[0] = 8'hC0;
    in_flit[4] = 8'hC4;
    for (int c = 0; c < 2; c++) begin
      #2;
      ack = bus.ACK;
      n_cmp++;
      if (ack !== acks[c]) begin n_bad++; $display("FAIL bub_ack%0d: got %b want %b", c, ack, acks[c]); end
      tick();
      for (int i = 0; i < W_DIR; i++) if (ack[i]) in_flit[i] = 8'h00;
      n_cmp++;
      if (bus.OUT[W_FLIT-1] !== vbits[c]) begin n_bad++; $display("FAIL bub_valid%0d: got %b want %b", c, bus.OUT[W_FLIT-1], vbits[c]); end
      n_cmp++;
      if (bus.GRANT !== grants[c]) begin n_bad++; $display("FAIL bub_grant%0d: got %b want %b", c, bus.GRANT, grants[c]); end
    end
    in_flit[0] = 8'hC0;
    in_flit[2] = 8'hA2;
    in_flit[4] = 8'hC4;
    RST = 1'b1;
    #2;
    n_cmp++;
    if (bus.ACK !== 5'b00000) begin n_bad++; $display("FAIL bub_rst_ack: got %b want 00000", bus.ACK); end
    tick();
    RST = 1'b0;
    n_cmp++;
    if (bus.GRANT !== 5'b00000) begin n_bad++; $display("FAIL bub_rst_grant: got %b want 00000", bus.GRANT); end
    n_cmp++;
    if (bus.OUT !== 8'h00) begin n_bad++; $display("FAIL bub_rst_out: got %h want 00", bus.OUT); end
    #2;
    n_cmp++;
    if (bus.ACK !== 5'b00001) begin n_bad++; $display("FAIL bub_after_rst_ack: got %b want 00001", bus.ACK); end
    tick();
    n_cmp++;
    if (bus.OUT !== 8'hC0) begin n_bad++; $display("FAIL bub_after_rst_out: got %h want c0", bus.OUT); end
    clear_inputs();
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    rdy = 1'b1;
    in_flit[0] = 8'hC9;
    for (int c = 1; c <= 256; c++) begin
      tick();
      if (c == 255) begin
        n_cmp++;
        if (bus.PKT_CNT !== 8'd255) begin n_bad++; $display("FAIL cnt_255: got %0d want 255", bus.PKT_CNT); end
      end
    end
    n_cmp++;
    if (bus.PKT_CNT !== 8'd0) begin n_bad++; $display("FAIL cnt_wrap: got %0d want 0", bus.PKT_CNT); end
    clear_inputs();
  endtask

  task automatic test_random();
    int win;
    int p;
    bit free;
    logic [W_DIR-1:0] e_ack;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < W_DIR; i++) begin
        if ($urandom_range(0, 3) != 0)
          in_flit[i] = {1'b1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63))};
        else
          in_flit[i] = 8'h00;
      end
      rdy = ($urandom_range(0, 3) != 0);
      RST = ($urandom_range(0, 199) == 0);
      free = !m_out[W_FLIT-1] || rdy;
      win = -1;
      if (!RST && free) begin
        if (m_own >= 0) begin
          if (in_flit[m_own][W_FLIT-1]) win = m_own;
        end else begin
          for (int k = 0; k < W_DIR; k++) begin
            p = (m_ptr + k) % W_DIR;
            if (win < 0 && in_flit[p][W_FLIT-1]) win = p;
          end
        end
      end
      e_ack = '0;
      if (win >= 0) e_ack[win] = 1'b1;
      #2;
      n_cmp++;
      if (bus.ACK !== e_ack) begin n_bad++; $display("FAIL rnd_ack@%0d: got %b want %b", cyc, bus.ACK, e_ack); end
      tick();
      if (RST) begin
        m_out = '0; m_grant = '0; m_ptr = 0; m_own = -1; m_cnt = '0;
      end else if (free) begin
        if (win >= 0) begin
          m_out = in_flit[win];
          if (m_out[W_FLIT-2]) m_cnt = m_cnt + 8'd1;
`ifdef FLIT_ARB_PKT_LOCK_EN
          if (m_out[W_FLIT-2]) begin
            m_own = -1; m_grant = '0; m_ptr = (win + 1) % W_DIR;
          end else begin
            m_own = win; m_grant = '0; m_grant[win] = 1'b1;
          end
`else
          m_grant = '0; m_grant[win] = 1'b1; m_ptr = (win + 1) % W_DIR;
`endif
        end else begin
          m_out = '0;
`ifndef FLIT_ARB_PKT_LOCK_EN
          m_grant = '0;
`endif
        end
      end
      n_cmp++;
      if (m_out[W_FLIT-1] ? (bus.OUT !== m_out) : (bus.OUT[W_FLIT-1] !== 1'b0)) begin
        n_bad++; $display("FAIL rnd_out@%0d: got %h want %h", cyc, bus.OUT, m_out);
      end
      n_cmp++;
      if (bus.GRANT !== m_grant) begin n_bad++; $display("FAIL rnd_grant@%0d: got %b want %b", cyc, bus.GRANT, m_grant); end
      n_cmp++;
      if (bus.PKT_CNT !== m_cnt) begin n_bad++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", cyc, bus.PKT_CNT, m_cnt); end
    end
    RST = 1'b0;
    clear_inputs();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_round_robin();
    test_backpressure();
    test_interleave();
`ifdef FLIT_ARB_PKT_LOCK_EN
    test_lock();
`endif
    test_bubble_reset();
    test_cnt_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
